// File: rtl/alu_pipe_n_if.sv
// Operand/result bundle between the register-file read ports, the sliced ALU and writeback.
interface alu_pipe_n_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             ivalid;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             icf;
    logic             ovalid;
    logic [WIDTH-1:0] out;
    logic             ocf;
    logic             ozf;
    logic             onf;
    logic             ovf;

    modport master (
        output en, ivalid, op, in1, in2, icf,
        input  ovalid, out, ocf, ozf, onf, ovf
    );

    modport slave (
        input  en, ivalid, op, in1, in2, icf,
        output ovalid, out, ocf, ozf, onf, ovf
    );
endinterface

// File: rtl/alu_pipe_n.sv
// Pipelined ALU: the WIDTH-bit carry chain is cut into STAGES slices, one slice per clock.
// Operands shift down one slice per stage; result slices enter at the top so they emerge aligned.
module alu_pipe_n #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    alu_pipe_n_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    function automatic logic [SW:0] slice_alu(input logic [1:0] op, input logic [SW-1:0] a,
                                              input logic [SW-1:0] b, input logic ci);
        logic [SW:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
        case (op)
            OP_AND:  slice_alu = {1'b0, a & b};
            OP_XOR:  slice_alu = {1'b0, a ^ b};
            default: slice_alu = sum;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] merge_slice(input logic [WIDTH-1:0] r,
                                                     input logic [SW-1:0] s);
        logic [WIDTH-1:0] m;
        m = r >> SW;
        m[WIDTH-1 -: SW] = s;
        return m;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_i;
        logic [1:0]       op_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] r_i;
        logic             c_i;
        logic [SW:0]      sl;
        logic             vld_q;
        logic [WIDTH-1:0] r_q;

        if (k == 0) begin : g_head
            // Stage 0 entry: SUB becomes IN1 + ~IN2 + ~ICF; logic ops get no carry-in.
            assign v_i  = bus.ivalid;
            assign op_i = bus.op;
            assign a_i  = bus.in1;
            assign b_i  = (bus.op == OP_SUB) ? ~bus.in2 : bus.in2;
            assign r_i  = '0;
            assign c_i  = (bus.op == OP_ADD) ? bus.icf :
                          (bus.op == OP_SUB) ? ~bus.icf : 1'b0;
        end else begin : g_body
            assign v_i  = g_stage[k-1].vld_q;
            assign op_i = g_stage[k-1].g_fwd.op_q;
            assign a_i  = g_stage[k-1].g_fwd.a_q;
            assign b_i  = g_stage[k-1].g_fwd.b_q;
            assign r_i  = g_stage[k-1].r_q;
            assign c_i  = g_stage[k-1].g_fwd.cy_q;
        end

        assign sl = slice_alu(op_i, a_i[SW-1:0], b_i[SW-1:0], c_i);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                r_q   <= '0;
            end else if (bus.en) begin
                vld_q <= v_i;
                r_q   <= merge_slice(r_i, sl[SW-1:0]);
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Stage k -> k+1 boundary: unprocessed operand slices and the slice carry move on.
            logic [1:0]       op_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             cy_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q <= '0;
                    a_q  <= '0;
                    b_q  <= '0;
                    cy_q <= 1'b0;
                end else if (bus.en) begin
                    op_q <= op_i;
                    a_q  <= a_i >> SW;
                    b_q  <= b_i >> SW;
                    cy_q <= sl[SW];
                end
            end
        end else begin : g_tail
            // Final boundary: flags are formed from the assembled result and registered with it.
            logic             arith;
            logic [WIDTH-1:0] res_n;
            logic             ocf_q;
            logic             ozf_q;
            logic             onf_q;
            logic             ovf_q;

            assign arith = ~op_i[1];
            assign res_n = merge_slice(r_i, sl[SW-1:0]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ocf_q <= 1'b0;
                    ozf_q <= 1'b0;
                    onf_q <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (bus.en) begin
                    ocf_q <= arith & (op_i[0] ? ~sl[SW] : sl[SW]);
                    ozf_q <= (res_n == '0);
                    onf_q <= res_n[WIDTH-1];
                    ovf_q <= arith & (a_i[SW-1] == b_i[SW-1]) & (sl[SW-1] != a_i[SW-1]);
                end
            end
        end
    end

    assign bus.ovalid = g_stage[STAGES-1].vld_q;
    assign bus.out    = g_stage[STAGES-1].r_q;
    assign bus.ocf    = g_stage[STAGES-1].g_tail.ocf_q;
    assign bus.ozf    = g_stage[STAGES-1].g_tail.ozf_q;
    assign bus.onf    = g_stage[STAGES-1].g_tail.onf_q;
    assign bus.ovf    = g_stage[STAGES-1].g_tail.ovf_q;
endmodule

// File: tb/tb_alu_pipe_n.sv
// Scoreboard bench for alu_pipe_n: a 16-bit/2-stage and a 32-bit/4-stage instance run side by side.
module tb_alu_pipe_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    alu_pipe_n_if #(.WIDTH(16)) if0 ();
    alu_pipe_n_if #(.WIDTH(32)) if1 ();

    alu_pipe_n #(.WIDTH(16), .STAGES(2)) u0 (.clk(clk), .rst(rst0), .bus(if0));
    alu_pipe_n #(.WIDTH(32), .STAGES(4)) u1 (.clk(clk), .rst(rst1), .bus(if1));

    typedef struct {
        logic [31:0] out;
        logic        cf;
        logic        zf;
        logic        nf;
        logic        vf;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   ecnt0 = 0;
    int   ecnt1 = 0;

    // Reference: plain integer arithmetic on w-bit values, signed overflow by range check.
    function automatic exp_t model(input int w, input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci, input int due);
        exp_t   e;
        longint ua, ub, uc, r, sa, sb, s, lim;
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        uc  = ci ? 64'sd1 : 64'sd0;
        lim = 64'sd1 <<< (w - 1);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sb  = (ub >= lim) ? ub - 2 * lim : ub;
        e.cf = 1'b0;
        e.vf = 1'b0;
        case (op)
            2'b00: begin
                r    = ua + ub + uc;
                e.cf = (r >= 2 * lim);
                s    = sa + sb + uc;
                e.vf = (s >= lim) || (s < -lim);
            end
            2'b01: begin
                r    = ua - ub - uc;
                e.cf = (ua < ub + uc);
                s    = sa - sb - uc;
                e.vf = (s >= lim) || (s < -lim);
            end
            2'b10:   r = ua & ub;
            default: r = ua ^ ub;
        endcase
        r     = r & (2 * lim - 1);
        e.out = r[31:0];
        e.zf  = (r == 0);
        e.nf  = (r >= lim);
        e.due = due;
        return e;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        logic [31:0] v;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = m;
            2:       v = 32'd1 << (w - 1);
            3:       v = (32'd1 << (w - 1)) - 32'd1;
            default: v = $urandom & m;
        endcase
        return v;
    endfunction

    task automatic check(input string nm, input exp_t e, input logic [31:0] o, input logic c,
                         input logic z, input logic n, input logic v, input int now);
        n_vec++;
        if (o !== e.out || c !== e.cf || z !== e.zf || n !== e.nf || v !== e.vf || now != e.due) begin
            n_bad++;
            $display("FAIL %s: got out=%h c=%b z=%b n=%b v=%b at edge %0d, want out=%h c=%b z=%b n=%b v=%b at edge %0d",
                     nm, o, c, z, n, v, now, e.out, e.cf, e.zf, e.nf, e.vf, e.due);
        end
    endtask

    // Monitors: one pop per EN=1 edge presenting OVALID; reset discards in-flight expectations.
    initial begin
        logic adv, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            rs  = rst0;
            adv = if0.en;
            #1;
            if (rs) q0.delete();
            else if (adv) begin
                ecnt0++;
                if (if0.ovalid) begin
                    if (q0.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL dut0 unexpected result: out=%h ovalid=1, want no result", if0.out);
                    end else begin
                        e = q0.pop_front();
                        check("dut0 result", e, {16'd0, if0.out}, if0.ocf, if0.ozf, if0.onf, if0.ovf, ecnt0);
                    end
                end else if (q0.size() != 0 && q0[0].due <= ecnt0) begin
                    n_vec++; n_bad++;
                    $display("FAIL dut0 dropped: ovalid=0 at edge %0d, want out=%h", ecnt0, q0[0].out);
                    void'(q0.pop_front());
                end
            end
        end
    end

    initial begin
        logic adv, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            rs  = rst1;
            adv = if1.en;
            #1;
            if (rs) q1.delete();
            else if (adv) begin
                ecnt1++;
                if (if1.ovalid) begin
                    if (q1.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL dut1 unexpected result: out=%h ovalid=1, want no result", if1.out);
                    end else begin
                        e = q1.pop_front();
                        check("dut1 result", e, if1.out, if1.ocf, if1.ozf, if1.onf, if1.ovf, ecnt1);
                    end
                end else if (q1.size() != 0 && q1[0].due <= ecnt1) begin
                    n_vec++; n_bad++;
                    $display("FAIL dut1 dropped: ovalid=0 at edge %0d, want out=%h", ecnt1, q1[0].out);
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic issue0(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic ci);
        @(negedge clk);
        if0.en = 1'b1; if0.ivalid = 1'b1; if0.op = op; if0.in1 = a; if0.in2 = b; if0.icf = ci;
        q0.push_back(model(16, op, {16'd0, a}, {16'd0, b}, ci, ecnt0 + 2));
    endtask

    task automatic issue1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci);
        @(negedge clk);
        if1.en = 1'b1; if1.ivalid = 1'b1; if1.op = op; if1.in1 = a; if1.in2 = b; if1.icf = ci;
        q1.push_back(model(32, op, a, b, ci, ecnt1 + 4));
    endtask

    task automatic idle0(input int n, input logic en);
        repeat (n) begin
            @(negedge clk);
            if0.en = en; if0.ivalid = 1'b0; if0.op = 2'($urandom);
            if0.in1 = 16'($urandom); if0.in2 = 16'($urandom); if0.icf = 1'($urandom);
        end
    endtask

    task automatic idle1(input int n, input logic en);
        repeat (n) begin
            @(negedge clk);
            if1.en = en; if1.ivalid = 1'b0; if1.op = 2'($urandom);
            if1.in1 = $urandom; if1.in2 = $urandom; if1.icf = 1'($urandom);
        end
    endtask

    task automatic chk_zero0(input string nm);
        n_vec++;
        if ({if0.ovalid, if0.out, if0.ocf, if0.ozf, if0.onf, if0.ovf} !== 21'd0) begin
            n_bad++;
            $display("FAIL %s: got ovalid=%b out=%h c=%b z=%b n=%b v=%b, want all zero",
                     nm, if0.ovalid, if0.out, if0.ocf, if0.ozf, if0.onf, if0.ovf);
        end
    endtask

    task automatic reset0(input logic en, input string nm);
        @(negedge clk);
        rst0 = 1'b1; if0.en = en; if0.ivalid = 1'b1;
        @(posedge clk);
        #2;
        chk_zero0(nm);
        @(negedge clk);
        rst0 = 1'b0; if0.ivalid = 1'b0;
    endtask

    task automatic rand0(input int n);
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        ci, en, iv;
        repeat (n) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            iv = ($urandom_range(0, 3) != 0);
            op = 2'($urandom); a = pick(16); b = pick(16); ci = 1'($urandom);
            if0.en = en; if0.ivalid = iv; if0.op = op; if0.in1 = a[15:0]; if0.in2 = b[15:0]; if0.icf = ci;
            if (en && iv) q0.push_back(model(16, op, a, b, ci, ecnt0 + 2));
        end
    endtask

    task automatic rand1(input int n);
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        ci, en, iv;
        repeat (n) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            iv = ($urandom_range(0, 3) != 0);
            op = 2'($urandom); a = pick(32); b = pick(32); ci = 1'($urandom);
            if1.en = en; if1.ivalid = iv; if1.op = op; if1.in1 = a; if1.in2 = b; if1.icf = ci;
            if (en && iv) q1.push_back(model(32, op, a, b, ci, ecnt1 + 4));
        end
    endtask

    task automatic seq0();
        exp_t ea;
        reset0(1'b0, "dut0 reset state");
        issue0(2'b00, 16'h01FF, 16'h0102, 1'b0);
        issue0(2'b00, 16'h1F05, 16'h0100, 1'b0);
        issue0(2'b00, 16'h0000, 16'h0000, 1'b0);
        idle0(3, 1'b1);
        issue0(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        issue0(2'b00, 16'hFFFF, 16'h0000, 1'b1);
        issue0(2'b01, 16'h0000, 16'h0001, 1'b0);
        issue0(2'b01, 16'h8000, 16'h0001, 1'b0);
        issue0(2'b10, 16'hF0F0, 16'h3C3C, 1'b1);
        issue0(2'b11, 16'hF0F0, 16'h3C3C, 1'b1);
        idle0(3, 1'b1);
        // Stall with both operations in flight; the first sits on the outputs.
        issue0(2'b00, 16'h1234, 16'h0FFF, 1'b1);
        ea = q0[0];
        issue0(2'b01, 16'h0100, 16'h0200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if0.en = 1'b0; if0.ivalid = 1'b1; if0.in1 = 16'($urandom); if0.in2 = 16'($urandom);
            @(posedge clk);
            #2;
            n_vec++;
            if (if0.ovalid !== 1'b1 || if0.out !== ea.out[15:0] || if0.ocf !== ea.cf ||
                if0.ozf !== ea.zf || if0.onf !== ea.nf || if0.ovf !== ea.vf) begin
                n_bad++;
                $display("FAIL dut0 stall hold %0d: got ovalid=%b out=%h c=%b, want ovalid=1 out=%h c=%b",
                         i, if0.ovalid, if0.out, if0.ocf, ea.out[15:0], ea.cf);
            end
        end
        idle0(3, 1'b1);
        issue0(2'b00, 16'h4444, 16'h1111, 1'b0);
        issue0(2'b11, 16'hAAAA, 16'h5555, 1'b0);
        reset0(1'b1, "dut0 reset mid-flight");
        idle0(4, 1'b1);
        issue0(2'b01, 16'h9000, 16'h0001, 1'b1);
        issue0(2'b00, 16'h00FF, 16'h0001, 1'b0);
        reset0(1'b0, "dut0 reset with en=0");
        idle0(4, 1'b1);
        rand0(400);
    endtask

    task automatic seq1();
        @(negedge clk);
        rst1 = 1'b1; if1.en = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        issue1(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        issue1(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue1(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b1);
        idle1(5, 1'b1);
        rand1(500);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        if0.en = 1'b0; if0.ivalid = 1'b0; if0.op = 2'b00; if0.in1 = '0; if0.in2 = '0; if0.icf = 1'b0;
        if1.en = 1'b0; if1.ivalid = 1'b0; if1.op = 2'b00; if1.in1 = '0; if1.in2 = '0; if1.icf = 1'b0;
        fork
            seq0();
            seq1();
        join
        fork
            idle0(6, 1'b1);
            idle1(8, 1'b1);
        join
        @(negedge clk);
        n_vec++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL dut0 drain: %0d results outstanding, want 0", q0.size());
        end
        n_vec++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL dut1 drain: %0d results outstanding, want 0", q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe_n.md
Name: alu_pipe_n

Overview:
Parametrised successor to the two-stage pipelined ALU. It splits a WIDTH-bit carry chain into STAGES equal slices and computes one slice per clock, so the ALU closes timing at wider datapaths. It adds an opcode, valid tracking, a pipeline-wide stall and a signed overflow flag. It sits between the register-file read ports and the writeback/flag register of the datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 2, pipeline depth; slice width SW = WIDTH/STAGES; legal values 1..WIDTH.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous active-high reset.
EN  input  1  pipeline advance; 0 freezes every pipeline register (stall).
IVALID  input  1  operands/opcode valid this cycle.
OP  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
IN1  input  WIDTH  operand A.
IN2  input  WIDTH  operand B.
ICF  input  1  carry-in for ADD, borrow-in for SUB; ignored for logic ops.
OVALID  output  1  OUT/flags hold a completed result.
OUT  output  WIDTH  result.
OCF  output  1  carry-out (ADD), borrow-out (SUB), 0 for logic ops.
OZF  output  1  OUT == 0.
ONF  output  1  OUT[WIDTH-1].
OVF  output  1  signed overflow for ADD/SUB, 0 for logic ops.

Behaviour:
- Reset: RST=1 at a rising edge clears all stage registers. OUT=0, OVALID=0, OCF=0, OZF=0, ONF=0, OVF=0. RST has priority over EN, and a reset mid-operation discards all in-flight operations.
- Advance: on an edge with EN=1 every stage shifts by one. Stage 0 captures IN1, IN2, OP, ICF and IVALID; IVALID=0 inserts a bubble. With EN=0 all registers, including outputs, hold their values.
- Latency: an operation accepted on edge t appears on OUT/flags/OVALID after edge t+STAGES-1 (STAGES EN=1 edges total). Throughput is one operation per EN=1 cycle.
- Slice k (0 = LSB) is computed in stage k, using the carry registered from stage k-1. Unprocessed upper operand slices travel with the operation; finished lower result slices are delayed so all slices emerge aligned.
- ADD: OUT = IN1 + IN2 + ICF (mod 2^WIDTH); OCF = bit WIDTH of the full sum.
- SUB: computed as IN1 + ~IN2 + ~ICF. OUT = IN1 - IN2 - ICF; OCF = ~carry (1 means borrow). Stage 0 carry-in is ~ICF.
- OVF (ADD/SUB): set when the operand MSBs (effective, i.e. IN1 and ~IN2 for SUB) are equal and the result MSB differs from them.
- AND/XOR are bitwise, pass through the same stages with the same latency, and force OCF=0, OVF=0.
- OZF is evaluated on the full assembled WIDTH-bit result in the last stage and registered with OUT. ONF equals OUT[WIDTH-1].
- Bubbles: when a bubble reaches the output, OVALID=0 and OUT/flags still update with whatever the bubble carries. Consumers must qualify on OVALID.
- STAGES=1: the block degenerates to a single registered ALU with latency 1.
- Back-to-back operations with different OP values never interact; each operation carries its own OP and carry chain.

Test Plan:
- Default params, ADD IN1=01FF IN2=0102 ICF=0 on 3 consecutive edges with IN1=1F05/IN2=0100 then 0000/0000 -> OUT sequence 0301, 2005, 0000, each 2 edges after issue. OZF=1 only for the third; OCF=0, ONF=0, OVALID=1 for all three.
- ADD 7FFF+0001 ICF=0 -> OUT=8000, OVF=1, ONF=1, OCF=0. Then ADD FFFF+0000 ICF=1 -> OUT=0000, OCF=1, OZF=1, OVF=0. Checks the carry crossing the slice boundary.
- SUB 0000-0001 ICF=0 -> OUT=FFFF, OCF=1, ONF=1. Then SUB 8000-0001 -> OUT=7FFF, OVF=1. Then AND F0F0/3C3C -> 3030, XOR -> CCCC, with OCF=0 and OVF=0 for both.
- Stall: issue 2 operations, hold EN=0 for 3 cycles -> outputs and in-flight state are frozen. After EN returns to 1 the results appear in order with no loss or duplication.
- Reset mid-flight: issue 2 operations, assert RST for one edge -> next cycle OVALID=0, OUT=0, all flags 0, and neither operation ever emerges. Also RST=1 with EN=0 must still clear.
- WIDTH=32, STAGES=4: ADD 0000FFFF+00000001 -> 00010000 after 4 edges. Random back-to-back stream checked against a reference model.
